// File: rtl/uart_link_ctrl_if.sv
// Command and UART-side signal bundle for uart_link_ctrl.
// The slave modport is the sequencer; the master modport is the controller/UART side.
interface uart_link_ctrl_if;
    logic       cmd_valid;
    logic [7:0] cmd_code;
    logic       cmd_ready;
    logic [7:0] data_to_tx;
    logic       start_tx;
    logic       tx_busy;
    logic [7:0] data_received;
    logic       rx_done;
    logic       parity_error;
    logic       done;
    logic       ok;
    logic [2:0] attempts;
    logic       spwm_en;
    logic       link_fail;

    modport master (
        output cmd_valid, cmd_code, tx_busy, data_received, rx_done, parity_error,
        input  cmd_ready, data_to_tx, start_tx, done, ok, attempts, spwm_en, link_fail
    );

    modport slave (
        input  cmd_valid, cmd_code, tx_busy, data_received, rx_done, parity_error,
        output cmd_ready, data_to_tx, start_tx, done, ok, attempts, spwm_en, link_fail
    );
endinterface

// File: rtl/uart_link_ctrl.sv
// Echo-checked UART command sequencer with retry and fail-safe SPWM gating.
// Optional idle heartbeat is compiled in when LINK_HEARTBEAT_EN is defined.
module uart_link_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 240,
    parameter int unsigned GAP_CYCLES     = 24,
    parameter int unsigned MAX_RETRY      = 3,
    parameter logic [7:0]  CMD_ON         = 8'b11101110,
    parameter logic [7:0]  CMD_OFF        = 8'b01010101,
    parameter logic [7:0]  CMD_TOGGLE     = 8'b11000011
`ifdef LINK_HEARTBEAT_EN
    ,
    parameter logic [7:0]  HB_CODE        = 8'hA5,
    parameter int unsigned HB_PERIOD      = 24000
`endif
) (
    input logic              clk,
    input logic              reset,
    uart_link_ctrl_if.slave  link
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
    // GAP plus the following SEND cycle make up GAP_CYCLES idle cycles (GAP_CYCLES >= 2)
    localparam logic [GW-1:0] GAP_LAST    = GW'(GAP_CYCLES - 2);
    localparam logic [3:0]    MAX_RETRY_C = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND      = 3'd1,
        ST_WAIT_ECHO = 3'd2,
        ST_GAP       = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t        state_r, state_s;
    logic [7:0]    data_r, data_s;
    logic          start_r, start_s;
    logic          done_r, done_s;
    logic          ok_r, ok_s;
    logic [2:0]    attempts_r, attempts_s;
    logic [3:0]    att_cnt_r, att_cnt_s;
    logic          result_r, result_s;
    logic [TW-1:0] to_cnt_r, to_cnt_s;
    logic [GW-1:0] gap_cnt_r, gap_cnt_s;
    logic          spwm_r, spwm_s;
    logic          link_fail_r, link_fail_s;
    logic          ready_r, ready_s;
    logic          hb_active_r, hb_active_s;
    logic          accept_s;
    logic          echo_good_s;
    logic          hb_fire_s;
    logic [7:0]    hb_code_s;

    function automatic logic spwm_upd_f(input logic [7:0] code, input logic cur);
        logic nxt;
        case (code)
            CMD_ON:     nxt = 1'b1;
            CMD_OFF:    nxt = 1'b0;
            CMD_TOGGLE: nxt = ~cur;
            default:    nxt = cur;
        endcase
        return nxt;
    endfunction

    assign accept_s    = link.cmd_valid && ready_r;
    assign echo_good_s = link.rx_done && !link.parity_error && (link.data_received == data_r);

`ifdef LINK_HEARTBEAT_EN
    localparam int HW = $clog2(HB_PERIOD + 1);
    logic [HW-1:0] hb_cnt_r;

    assign hb_fire_s = (state_r == ST_IDLE) && spwm_r && !accept_s && (hb_cnt_r == HW'(HB_PERIOD - 1));
    assign hb_code_s = HB_CODE;

    // Consecutive enabled-idle cycles; any accept or leaving IDLE restarts it
    always_ff @(posedge clk) begin
        if (reset) begin
            hb_cnt_r <= {HW{1'b0}};
        end else if ((state_r == ST_IDLE) && spwm_r && !accept_s && !hb_fire_s) begin
            hb_cnt_r <= hb_cnt_r + HW'(1);
        end else begin
            hb_cnt_r <= {HW{1'b0}};
        end
    end
`else
    assign hb_fire_s = 1'b0;
    assign hb_code_s = 8'h00;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_s     = state_r;
        data_s      = data_r;
        start_s     = 1'b0;
        done_s      = 1'b0;
        ok_s        = ok_r;
        attempts_s  = attempts_r;
        att_cnt_s   = att_cnt_r;
        result_s    = result_r;
        to_cnt_s    = to_cnt_r;
        gap_cnt_s   = gap_cnt_r;
        spwm_s      = spwm_r;
        link_fail_s = link_fail_r;
        hb_active_s = hb_active_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    data_s      = link.cmd_code;
                    att_cnt_s   = 4'd1;
                    hb_active_s = 1'b0;
                    state_s     = ST_SEND;
                end else if (hb_fire_s) begin
                    data_s      = hb_code_s;
                    att_cnt_s   = 4'd1;
                    hb_active_s = 1'b1;
                    state_s     = ST_SEND;
                end else begin
                    state_s     = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (!link.tx_busy) begin
                    start_s  = 1'b1;
                    to_cnt_s = {TW{1'b0}};
                    state_s  = ST_WAIT_ECHO;
                end else begin
                    state_s  = ST_SEND;
                end
            end
            ST_WAIT_ECHO: begin
                to_cnt_s = to_cnt_r + TW'(1);
                // A good echo wins over a timeout landing in the same cycle
                if (echo_good_s) begin
                    result_s = 1'b1;
                    state_s  = ST_DONE;
                end else if (link.rx_done || (to_cnt_r == TO_LAST)) begin
                    if (att_cnt_r <= MAX_RETRY_C) begin
                        gap_cnt_s = {GW{1'b0}};
                        state_s   = ST_GAP;
                    end else begin
                        result_s  = 1'b0;
                        state_s   = ST_DONE;
                    end
                end else begin
                    state_s  = ST_WAIT_ECHO;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    att_cnt_s = att_cnt_r + 4'd1;
                    state_s   = ST_SEND;
                end else begin
                    gap_cnt_s = gap_cnt_r + GW'(1);
                end
            end
            ST_DONE: begin
                if (hb_active_r) begin
                    if (!result_r) begin
                        spwm_s      = 1'b0;
                        link_fail_s = 1'b1;
                    end else begin
                        spwm_s      = spwm_r;
                    end
                end else begin
                    done_s     = 1'b1;
                    ok_s       = result_r;
                    attempts_s = att_cnt_r[3] ? 3'd7 : att_cnt_r[2:0];
                    if (result_r) begin
                        spwm_s      = spwm_upd_f(data_r, spwm_r);
                        link_fail_s = 1'b0;
                    end else begin
                        spwm_s      = 1'b0;
                        link_fail_s = 1'b1;
                    end
                end
                hb_active_s = 1'b0;
                state_s     = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        ready_s = (state_s == ST_IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            data_r      <= 8'h00;
            start_r     <= 1'b0;
            done_r      <= 1'b0;
            ok_r        <= 1'b0;
            attempts_r  <= 3'd0;
            att_cnt_r   <= 4'd0;
            result_r    <= 1'b0;
            to_cnt_r    <= {TW{1'b0}};
            gap_cnt_r   <= {GW{1'b0}};
            spwm_r      <= 1'b0;
            link_fail_r <= 1'b0;
            ready_r     <= 1'b0;
            hb_active_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            data_r      <= data_s;
            start_r     <= start_s;
            done_r      <= done_s;
            ok_r        <= ok_s;
            attempts_r  <= attempts_s;
            att_cnt_r   <= att_cnt_s;
            result_r    <= result_s;
            to_cnt_r    <= to_cnt_s;
            gap_cnt_r   <= gap_cnt_s;
            spwm_r      <= spwm_s;
            link_fail_r <= link_fail_s;
            ready_r     <= ready_s;
            hb_active_r <= hb_active_s;
        end
    end

    assign link.cmd_ready  = ready_r;
    assign link.data_to_tx = data_r;
    assign link.start_tx   = start_r;
    assign link.done       = done_r;
    assign link.ok         = ok_r;
    assign link.attempts   = attempts_r;
    assign link.spwm_en    = spwm_r;
    assign link.link_fail  = link_fail_r;

endmodule

// File: tb/tb_uart_link_ctrl.sv
// Scoreboard bench for uart_link_ctrl: a UART echo model answers each start_tx,
// expected command results are queued at accept and compared at each done pulse.
module tb_uart_link_ctrl;

    localparam logic [7:0] CMD_ON     = 8'b11101110;
    localparam logic [7:0] CMD_OFF    = 8'b01010101;
    localparam logic [7:0] CMD_TOGGLE = 8'b11000011;
    localparam logic [7:0] CMD_UNK    = 8'h3C;
    localparam int ECHO_DLY = 20;
    localparam int M_LOOP = 0, M_SILENT = 1, M_CORRUPT = 2, M_PARITY = 3;

    typedef struct {
        logic       ok;
        logic [2:0] att;
        logic       spwm;
        logic       lf;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_link_ctrl_if link();

    uart_link_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .link  (link)
    );

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    exp_t sb_q[$];
    int start_q[$];
    int echo_mode = 0;
    int echo_cnt = 0;
    int bad_left = 0;
    logic [7:0] echo_data = 8'h00;
    int last_rx_cyc = 0;
    int bad_rx_cyc = 0;
    int done_cnt = 0;
    logic in_cmd = 1'b0;
    logic ready_leak = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic ok, input logic [2:0] att, input logic spwm, input logic lf);
        exp_t e;
        e.ok = ok; e.att = att; e.spwm = spwm; e.lf = lf;
        return e;
    endfunction

    // One clock: sample outputs, run the echo model and the scoreboard
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        link.rx_done      = 1'b0;
        link.parity_error = 1'b0;
        if (link.done === 1'b1) begin
            done_cnt++;
            check_eq("done_has_cmd", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_eq("ok", link.ok, e.ok);
                check_eq("attempts", link.attempts, e.att);
                check_eq("spwm_en", link.spwm_en, e.spwm);
                check_eq("link_fail", link.link_fail, e.lf);
                check_eq("ready_low_in_cmd", ready_leak, 0);
                if (e.ok) check_eq("echo_to_done", cyc - last_rx_cyc, 2);
                in_cmd = 1'b0;
            end
        end else if (in_cmd && link.cmd_ready === 1'b1) begin
            ready_leak = 1'b1;
        end
        if (link.start_tx === 1'b1) begin
            start_q.push_back(cyc);
            echo_data = link.data_to_tx;
            if (echo_mode != M_SILENT) echo_cnt = ECHO_DLY;
        end
        if (echo_cnt > 0) begin
            echo_cnt--;
            if (echo_cnt == 0) begin
                link.rx_done       = 1'b1;
                link.data_received = echo_data;
                if (bad_left > 0) begin
                    bad_left--;
                    bad_rx_cyc = cyc;
                    if (echo_mode == M_CORRUPT) link.data_received = 8'h00;
                    else link.parity_error = 1'b1;
                end else begin
                    last_rx_cyc = cyc;
                end
            end
        end
    endtask

    task automatic send_cmd(input logic [7:0] code, input int mode, input int nbad,
                            input exp_t e, input int busy_cycles);
        int n;
        int d0;
        int drop_cyc;
        n = 0;
        while (link.cmd_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check_eq("cmd_ready_wait", link.cmd_ready, 1);
        echo_mode = mode;
        bad_left  = nbad;
        start_q.delete();
        d0 = done_cnt;
        link.tx_busy   = (busy_cycles > 0);
        link.cmd_valid = 1'b1;
        link.cmd_code  = code;
        sb_q.push_back(e);
        in_cmd     = 1'b1;
        ready_leak = 1'b0;
        tick();
        link.cmd_valid = 1'b0;
        link.cmd_code  = 8'h00;
        check_eq("data_to_tx", link.data_to_tx, code);
        repeat (busy_cycles) tick();
        link.tx_busy = 1'b0;
        drop_cyc = cyc;
        n = 0;
        while (done_cnt == d0 && n < 3000) begin
            tick();
            n++;
        end
        check_eq("done_seen", done_cnt - d0, 1);
        if (start_q.size() > 0) check_eq("start_latency", start_q[0] - drop_cyc, 1);
        else check_eq("start_seen", start_q.size(), 1);
    endtask

    initial begin
        int d0;
        reset              = 1'b1;
        link.cmd_valid     = 1'b0;
        link.cmd_code      = 8'h00;
        link.tx_busy       = 1'b0;
        link.data_received = 8'h00;
        link.rx_done       = 1'b0;
        link.parity_error  = 1'b0;
        repeat (3) tick();
        check_eq("rst_cmd_ready", link.cmd_ready, 0);
        check_eq("rst_start_tx", link.start_tx, 0);
        check_eq("rst_data_to_tx", link.data_to_tx, 0);
        check_eq("rst_done", link.done, 0);
        check_eq("rst_ok", link.ok, 0);
        check_eq("rst_attempts", link.attempts, 0);
        check_eq("rst_spwm_en", link.spwm_en, 0);
        check_eq("rst_link_fail", link.link_fail, 0);
        reset = 1'b0;
        tick();
        check_eq("ready_after_rst", link.cmd_ready, 1);

        send_cmd(CMD_ON,     M_LOOP, 0, mk(1'b1, 3'd1, 1'b1, 1'b0), 0);
        send_cmd(CMD_TOGGLE, M_LOOP, 0, mk(1'b1, 3'd1, 1'b0, 1'b0), 0);
        send_cmd(CMD_TOGGLE, M_LOOP, 0, mk(1'b1, 3'd1, 1'b1, 1'b0), 0);
        send_cmd(CMD_UNK,    M_LOOP, 0, mk(1'b1, 3'd1, 1'b1, 1'b0), 0);
        send_cmd(CMD_OFF,    M_LOOP, 0, mk(1'b1, 3'd1, 1'b0, 1'b0), 6);

        send_cmd(CMD_TOGGLE, M_CORRUPT, 1, mk(1'b1, 3'd2, 1'b1, 1'b0), 0);
        check_eq("corrupt_starts", start_q.size(), 2);
        if (start_q.size() == 2) check_eq("retry_gap_ge24", (start_q[1] - bad_rx_cyc) >= 24, 1);

        send_cmd(CMD_ON, M_PARITY, 2, mk(1'b1, 3'd3, 1'b1, 1'b0), 0);
        check_eq("parity_starts", start_q.size(), 3);

        send_cmd(CMD_TOGGLE, M_SILENT, 0, mk(1'b0, 3'd4, 1'b0, 1'b1), 0);
        check_eq("silent_starts", start_q.size(), 4);
        for (int i = 1; i < start_q.size(); i++)
            check_eq("retry_spacing", start_q[i] - start_q[i-1], 264);

        send_cmd(CMD_OFF, M_LOOP, 0, mk(1'b1, 3'd1, 1'b0, 1'b0), 0);
        send_cmd(CMD_ON,  M_LOOP, 0, mk(1'b1, 3'd1, 1'b1, 1'b0), 0);

        // Reset while waiting for an echo that never comes
        echo_mode = M_SILENT;
        start_q.delete();
        link.cmd_valid = 1'b1;
        link.cmd_code  = CMD_OFF;
        tick();
        link.cmd_valid = 1'b0;
        repeat (30) tick();
        check_eq("mid_started", start_q.size(), 1);
        reset = 1'b1;
        tick();
        check_eq("mid_rst_spwm", link.spwm_en, 0);
        check_eq("mid_rst_start", link.start_tx, 0);
        tick();
        reset = 1'b0;
        tick();
        check_eq("mid_rst_ready", link.cmd_ready, 1);
        check_eq("mid_rst_link_fail", link.link_fail, 0);
        d0 = done_cnt;
        link.rx_done       = 1'b1;
        link.data_received = CMD_OFF;
        repeat (10) tick();
        check_eq("late_echo_no_done", done_cnt - d0, 0);

        send_cmd(CMD_ON, M_LOOP, 0, mk(1'b1, 3'd1, 1'b1, 1'b0), 0);
        check_eq("sb_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_link_ctrl.md
# uart_link_ctrl

Command sequencer between the main FPGA control logic and the inter-board UART link to the FPGA_modulo submodules. Takes one 8-bit command at a time from the local controller and drives `uart_tx`. It then checks the submodule's echo on `uart_rx` and retries on mismatch, parity error or timeout. It gates the SPWM enable of `phase_generator` according to acknowledged on, off and toggle commands, and fails safe to off when the link is lost.

## Interface
- `TIMEOUT_CYCLES`, 240: clk cycles from `start_tx` to the required echo (`rx_done`).
- `GAP_CYCLES`, 24: idle cycles inserted before each retry.
- `MAX_RETRY`, 3: retries after the first attempt; total attempts is `MAX_RETRY+1`, range 0..7.
- `CMD_ON`, 8'b11101110 / `CMD_OFF`, 8'b01010101 / `CMD_TOGGLE`, 8'b11000011: command codes.
- `HB_CODE`, 8'hA5 / `HB_PERIOD`, 24000: heartbeat code and idle period in cycles (only with `LINK_HEARTBEAT_EN`).
- `clk` in 1: system clock, 24 MHz.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command request.
- `cmd_code` in 8: command byte, sampled when `cmd_valid && cmd_ready`.
- `cmd_ready` out 1: block is in IDLE and accepts a command.
- `data_to_tx` out 8: byte to `uart_tx`.
- `start_tx` out 1: one-cycle start pulse to `uart_tx`.
- `tx_busy` in 1: from `uart_tx`.
- `data_received` in 8, `rx_done` in 1, `parity_error` in 1: from `uart_rx`.
- `done` out 1: one-cycle pulse when a command completes.
- `ok` out 1: result of the last command, valid from `done` until the next `done`.
- `attempts` out 3: number of attempts used by the last command, 1..`MAX_RETRY+1`.
- `spwm_en` out 1: enable for `phase_generator`; the top ties the generator's `reset` to `~spwm_en`.
- `link_fail` out 1: sticky; set on a failed command, cleared by a successful command or by `reset`.

## Operation
- Reset values:
  - `cmd_ready`=0 during reset and 1 in the first cycle after.
  - `start_tx`=0, `data_to_tx`=0, `done`=0, `ok`=0, `attempts`=0.
  - `spwm_en`=0, `link_fail`=0; state is IDLE and all counters are 0.
- IDLE:
  - `cmd_ready`=1.
  - On accept, latch `cmd_code` into `data_to_tx`, set the attempt count to 1 and go to SEND.
- SEND:
  - Wait while `tx_busy`=1.
  - In the first cycle with `tx_busy`=0, pulse `start_tx`, clear the timeout counter and go to WAIT_ECHO.
- WAIT_ECHO:
  - The timeout counter increments every cycle.
  - On the first `rx_done` with `parity_error`=0 and `data_received==data_to_tx`, go to DONE with `ok`=1.
  - On `rx_done` with a mismatch or `parity_error`=1, or when the counter reaches `TIMEOUT_CYCLES`, the attempt fails.
  - After a failed attempt, go to GAP if attempts ≤ `MAX_RETRY`, otherwise go to DONE with `ok`=0.
- GAP:
  - Count `GAP_CYCLES`, then increment `attempts` and return to SEND.
  - `rx_done` during GAP is ignored.
- DONE:
  - One cycle: pulse `done` and publish `attempts`.
  - Update `spwm_en`:
    - If `ok` and code is `CMD_ON`, set `spwm_en`=1.
    - If `ok` and code is `CMD_OFF`, clear `spwm_en`.
    - If `ok` and code is `CMD_TOGGLE`, invert `spwm_en`.
    - If not `ok`, force `spwm_en`=0 and set `link_fail`.
  - Go to IDLE.
- Unknown codes are sent and echo-checked like any other command but leave `spwm_en` unchanged.
- `rx_done` in IDLE is ignored.
- `data_to_tx` stays stable from accept until the next accept.

## Timing
- Accept to `start_tx`: 1 cycle when `tx_busy`=0, otherwise 1 cycle after `tx_busy` falls.
- Valid echo `rx_done` at cycle N: `done` and the updated `spwm_en` appear at N+2.
- Timeout: a failed attempt is declared exactly `TIMEOUT_CYCLES` cycles after `start_tx`.
- `rx_done` and timeout in the same cycle: `rx_done` takes priority.
- Worst-case command latency is about (`MAX_RETRY+1`)·(`TIMEOUT_CYCLES`+`GAP_CYCLES`+2) cycles.
- `reset` asserted mid-operation:
  - Next state is IDLE, `start_tx` is 0 on the following edge and `spwm_en` drops.
  - A `uart_tx` frame already in progress is allowed to finish; its echo is ignored.

## Configuration
- `LINK_HEARTBEAT_EN` defined:
  - After `HB_PERIOD` consecutive cycles in IDLE with `spwm_en`=1, send `HB_CODE` using the normal retry sequence.
  - While the heartbeat is in progress `cmd_ready`=0.
  - The heartbeat raises no `done` pulse; a failed heartbeat clears `spwm_en` and sets `link_fail`.
  - The idle counter clears on any accept.
- `LINK_HEARTBEAT_EN` undefined:
  - No heartbeat logic; the `HB_*` parameters are unused.
  - The link is checked only when a command is issued.

## Test plan
- Send `CMD_ON` with a loopback echo (rx tied to tx) → `done` pulse, `ok`=1, `attempts`=1, `spwm_en`=1.
- With `spwm_en`=1, send `CMD_TOGGLE` twice → `spwm_en` goes 0 then 1, and `cmd_ready` stays low between accept and `done`.
- Return a corrupted first echo (8'h00), then correct echoes → `ok`=1, `attempts`=2, and the second `start_tx` comes ≥24 cycles after the first failure.
- Return no echo at all → 4 `start_tx` pulses spaced 264 cycles apart, then `ok`=0, `spwm_en`=0, `link_fail`=1; a following successful `CMD_OFF` clears `link_fail`.
- Assert `reset` during WAIT_ECHO with `spwm_en`=1 → `spwm_en`=0, `cmd_ready`=1 after release, and a late `rx_done` produces no `done`.
- With `LINK_HEARTBEAT_EN`, `spwm_en`=1 and no echo → 4 `HB_CODE` transmissions starting 24000 idle cycles after the last `done`, then `spwm_en`=0.
